// File: rtl/output_pipe_pkg.sv
// Shared constants, state encoding and lane helper for the output pipeline.
package output_pipe_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned WORD_W      = 128;
   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned INDEX_W     = ADDR_W - 1;
   localparam int unsigned LANES       = WORD_W / DATA_W;
   localparam int unsigned LANE_W      = $clog2(LANES);
   localparam int unsigned FRAME_WORDS = 19200;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PACK,
      ST_DONE
   } state_t;

   // Bit offset of a byte lane inside the packed word.
   function automatic int unsigned lane_slice(input logic [LANE_W-1:0] lane);
      return int'(lane) * DATA_W;
   endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// Packs incoming bytes into a 16-lane word; lane 0 is the first byte of each word.
module byte_lane_packer
   import output_pipe_pkg::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic              valid,
   input  logic [DATA_W-1:0] byte_in,
   output logic [WORD_W-1:0] word_out,
   output logic              word_full
);

   logic [LANE_W-1:0] lane;
   logic [WORD_W-1:0] word_q;

   // Lane counter: restarts on clear, advances once per accepted byte.
   always_ff @(posedge clock) begin
      if (clear) begin
         lane <= '0;
      end else if (valid) begin
         lane <= lane + LANE_W'(1);
      end
   end

   // Lane storage.
   // NOTE: the data register has no reset; every lane is rewritten before a word can complete, so only the counter needs clearing.
   always_ff @(posedge clock) begin
      if (valid && !clear) begin
         word_q[lane_slice(lane) +: DATA_W] <= byte_in;
      end
   end

   // The word as it will look after this edge, so the last byte is included in the same cycle it arrives.
   always_comb begin
      word_out = word_q;
      word_out[lane_slice(lane) +: DATA_W] = byte_in;
   end

   assign word_full = valid && !clear && (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/output_store_mem.sv
// Write-side stage: packs the byte stream into 128-bit words and strobes them into
// frame memory at {buffer select, word index}; flags Done once a full frame is stored.
module output_store_mem #(
   parameter int unsigned FRAME_WORDS = output_pipe_pkg::FRAME_WORDS
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                output_base_offset,
   input  logic                                byte_valid,
   input  logic [output_pipe_pkg::DATA_W-1:0]  byte_in,
   output logic [output_pipe_pkg::ADDR_W-1:0]  WriteAddress,
   output logic [output_pipe_pkg::WORD_W-1:0]  WriteBus,
   output logic                                WriteEnable,
   output logic                                Busy,
   output logic                                Done
);

   import output_pipe_pkg::*;

   localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(FRAME_WORDS - 1);

   state_t              state;
   logic                base;
   logic [INDEX_W-1:0]  index;
   logic                final_pending;  // last word of the frame has been strobed
   logic                pack_clear;
   logic                pack_valid;
   logic [WORD_W-1:0]   pack_word;
   logic                pack_full;

   // Packer only runs while a frame is active and the last word is not yet out;
   // leaving PACK (abort, reset or done) discards any partial word.
   assign pack_clear = reset || (state != ST_PACK) || !start;
   assign pack_valid = byte_valid && !final_pending;

   byte_lane_packer u_packer (
      .clock     (clock),
      .clear     (pack_clear),
      .valid     (pack_valid),
      .byte_in   (byte_in),
      .word_out  (pack_word),
      .word_full (pack_full)
   );

   // Frame FSM with index counter and registered write port.
   // NOTE: all state and outputs live in one clocked block using non-blocking assignments, so every output is a clean flop.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         base          <= 1'b0;
         index         <= '0;
         final_pending <= 1'b0;
         WriteAddress  <= '0;
         WriteBus      <= '0;
         WriteEnable   <= 1'b0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
      end else begin
         WriteEnable   <= 1'b0;
         final_pending <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_PACK;
                  base  <= output_base_offset;
                  index <= '0;
                  Busy  <= 1'b1;
                  Done  <= 1'b0;
               end
            end
            ST_PACK: begin
               if (!start) begin
                  state <= ST_IDLE;
                  Busy  <= 1'b0;
               end else if (final_pending) begin
                  state <= ST_DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else if (pack_full) begin
                  WriteEnable  <= 1'b1;
                  WriteBus     <= pack_word;
                  WriteAddress <= {base, index};
                  if (index == LAST_INDEX) begin
                     final_pending <= 1'b1;
                  end else begin
                     index <= index + INDEX_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (!start) begin
                  state <= ST_IDLE;
                  Done  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_store_mem.sv
// Directed bench for output_store_mem: full frames (continuous and gapped), abort,
// reset with a pending strobe, post-Done behaviour, and a table-driven restart sequence.
module tb_output_store_mem;

   localparam int unsigned F = 40;  // frame length used by this bench

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         output_base_offset;
   logic         byte_valid;
   logic [7:0]   byte_in;
   logic [15:0]  WriteAddress;
   logic [127:0] WriteBus;
   logic         WriteEnable;
   logic         Busy;
   logic         Done;

   int checks = 0;
   int errors = 0;

   output_store_mem #(.FRAME_WORDS(F)) dut (
      .clock              (clock),
      .reset              (reset),
      .start              (start),
      .output_base_offset (output_base_offset),
      .byte_valid         (byte_valid),
      .byte_in            (byte_in),
      .WriteAddress       (WriteAddress),
      .WriteBus           (WriteBus),
      .WriteEnable        (WriteEnable),
      .Busy               (Busy),
      .Done               (Done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic         start;
      logic         base;
      logic         valid;
      logic [7:0]   din;
      logic         exp_we;
      logic         exp_busy;
      logic         exp_done;
      logic [15:0]  exp_addr;
      logic [127:0] exp_bus;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_ctrl(input string tag, input logic we, input logic busy, input logic done);
      check({tag, " WriteEnable"}, 128'(WriteEnable), 128'(we));
      check({tag, " Busy"},        128'(Busy),        128'(busy));
      check({tag, " Done"},        128'(Done),        128'(done));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_ctrl(tag, 1'b0, 1'b0, 1'b0);
      check({tag, " WriteAddress"}, 128'(WriteAddress), 128'(0));
      check({tag, " WriteBus"},     WriteBus,           128'(0));
   endtask

   // Expected word k of a stream whose byte i has value i mod 256.
   function automatic logic [127:0] ramp_word(input int k);
      logic [127:0] w;
      for (int l = 0; l < 16; l++) w[8*l +: 8] = 8'((16*k + l) & 255);
      return w;
   endfunction

   function automatic logic [127:0] fill_word(input logic [7:0] b);
      logic [127:0] w;
      for (int l = 0; l < 16; l++) w[8*l +: 8] = b;
      return w;
   endfunction

   task automatic add_vec(input logic s, input logic b, input logic v, input logic [7:0] d,
                          input logic we, input logic busy, input logic done,
                          input logic [15:0] addr, input logic [127:0] bus);
      vec_t x;
      x.start = s; x.base = b; x.valid = v; x.din = d;
      x.exp_we = we; x.exp_busy = busy; x.exp_done = done;
      x.exp_addr = addr; x.exp_bus = bus;
      vecs.push_back(x);
   endtask

   // One full frame of ramp data; gap=1 inserts an idle cycle after every byte.
   task automatic run_frame(input logic base, input bit gap);
      int strobes;
      logic [127:0] w;
      strobes = 0;
      start = 1'b1; output_base_offset = base; byte_valid = 1'b0; byte_in = 8'h00;
      step();
      check_ctrl("frame entry", 1'b0, 1'b1, 1'b0);
      output_base_offset = ~base;  // must not matter once sampled
      for (int i = 0; i < 16 * int'(F); i++) begin
         byte_valid = 1'b1; byte_in = 8'(i & 255);
         step();
         if (i % 16 == 15) begin
            check("strobe WriteEnable", 128'(WriteEnable), 128'(1));
            if (WriteEnable) strobes++;
            check("strobe WriteAddress", 128'(WriteAddress), 128'({base, 15'(i / 16)}));
            check("strobe WriteBus", WriteBus, ramp_word(i / 16));
            check("strobe Done", 128'(Done), 128'(0));
         end else if (WriteEnable) begin
            check("unexpected strobe", 128'(WriteEnable), 128'(0));
         end
         if (gap) begin
            byte_valid = 1'b0; byte_in = 8'hFF;
            step();
            if (WriteEnable || i == 16 * int'(F) - 1)
               check("gap cycle WriteEnable", 128'(WriteEnable), 128'(0));
            if (i == 16 * int'(F) - 1)
               check("Done after last strobe", 128'(Done), 128'(1));
         end
      end
      if (!gap) begin
         byte_valid = 1'b0;
         step();
         check_ctrl("after last strobe", 1'b0, 1'b0, 1'b1);
      end
      check("strobe count", 128'(strobes), 128'(F));
      w = 128'h0F0E0D0C0B0A09080706050403020100;
      check("first word pattern", ramp_word(0), w);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; output_base_offset = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      step();
      check_reset_outputs("reset");
      reset = 1'b0;
      step();
      check_reset_outputs("idle");

      // Continuous stream into buffer 0; every word checked back-to-back.
      run_frame(1'b0, 1'b0);

      // Bytes after Done with start held are ignored.
      for (int i = 0; i < 32; i++) begin
         byte_valid = 1'b1; byte_in = 8'(i);
         step();
         check_ctrl("post-done", 1'b0, 1'b0, 1'b1);
      end
      start = 1'b0; byte_valid = 1'b0;
      step();
      check_ctrl("start low after done", 1'b0, 1'b0, 1'b0);

      // Gapped stream into buffer 1.
      run_frame(1'b1, 1'b1);
      start = 1'b0;
      step();
      check_ctrl("idle after frame 2", 1'b0, 1'b0, 1'b0);

      // Reset on the same edge as the 16th byte: the strobe never appears.
      start = 1'b1; output_base_offset = 1'b1;
      step();
      for (int i = 0; i < 16; i++) begin
         byte_valid = 1'b1; byte_in = 8'(8'h30 + i);
         if (i == 15) reset = 1'b1;
         step();
      end
      check_reset_outputs("reset on 16th byte");
      reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("no strobe after reset", 128'(WriteEnable), 128'(0));
      end

      // Reset while a strobe is visible: cancelled on the next cycle.
      start = 1'b1; output_base_offset = 1'b0;
      step();
      for (int i = 0; i < 16; i++) begin
         byte_valid = 1'b1; byte_in = 8'(8'h50 + i);
         step();
      end
      check("strobe before reset", 128'(WriteEnable), 128'(1));
      reset = 1'b1; byte_valid = 1'b0;
      step();
      check_reset_outputs("reset during strobe");
      reset = 1'b0; start = 1'b0;
      step();

      // Table: 10 bytes, one-cycle abort, restart with 16 bytes of 0xAA.
      add_vec(1, 0, 0, 8'h00, 0, 1, 0, 16'h0000, '0);
      for (int i = 0; i < 10; i++) add_vec(1, 0, 1, 8'(8'h11 * (i + 1)), 0, 1, 0, 16'h0000, '0);
      add_vec(0, 1, 1, 8'h55, 0, 0, 0, 16'h0000, '0);
      add_vec(1, 0, 0, 8'h00, 0, 1, 0, 16'h0000, '0);
      for (int i = 0; i < 15; i++) add_vec(1, 1, 1, 8'hAA, 0, 1, 0, 16'h0000, '0);
      add_vec(1, 1, 1, 8'hAA, 1, 1, 0, 16'h0000, fill_word(8'hAA));
      add_vec(1, 1, 0, 8'h00, 0, 1, 0, 16'h0000, '0);
      add_vec(0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, '0);
      for (int n = 0; n < vecs.size(); n++) begin
         start = vecs[n].start; output_base_offset = vecs[n].base;
         byte_valid = vecs[n].valid; byte_in = vecs[n].din;
         step();
         check($sformatf("vec%0d WriteEnable", n), 128'(WriteEnable), 128'(vecs[n].exp_we));
         check($sformatf("vec%0d Busy", n),        128'(Busy),        128'(vecs[n].exp_busy));
         check($sformatf("vec%0d Done", n),        128'(Done),        128'(vecs[n].exp_done));
         if (vecs[n].exp_we) begin
            check($sformatf("vec%0d WriteAddress", n), 128'(WriteAddress), 128'(vecs[n].exp_addr));
            check($sformatf("vec%0d WriteBus", n),     WriteBus,           vecs[n].exp_bus);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
